// File: rtl/if_fetch_pkg.sv
// Shared widths, fetch FSM encodings and the skid-entry type for the
// instruction-fetch stage.
package if_fetch_pkg;
   localparam int INST_ADDR_BUS   = 32;
   localparam int INST_BUS        = 32;
   localparam int FETCH_STATE_BUS = 2;

   localparam logic [INST_BUS-1:0] ZERO_WORD = '0;

   localparam logic [FETCH_STATE_BUS-1:0] IDLE    = 2'd0;
   localparam logic [FETCH_STATE_BUS-1:0] REQ     = 2'd1;
   localparam logic [FETCH_STATE_BUS-1:0] HOLD    = 2'd2;
   localparam logic [FETCH_STATE_BUS-1:0] DISCARD = 2'd3;

   typedef struct packed {
      logic [INST_ADDR_BUS-1:0] pc;
      logic [INST_BUS-1:0]      inst;
   } fetch_entry_t;

   function automatic logic [INST_ADDR_BUS-1:0] word_align(input logic [INST_ADDR_BUS-1:0] a);
      return {a[INST_ADDR_BUS-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface if_fetch_if import if_fetch_pkg::*;;
   logic                     imemReq;
   logic [INST_ADDR_BUS-1:0] imemAddr;
   logic                     imemAck;
   logic [INST_BUS-1:0]      imemData;

   modport master (output imemReq, output imemAddr, input imemAck, input imemData);
   modport slave  (input imemReq, input imemAddr, output imemAck, output imemData);
endinterface

// File: rtl/if_skid_buf.sv
// One-entry {pc,inst,valid} holding register that parks a fetched word while
// the IF/ID register is stalled. Clear wins over load, load over unload.
module if_skid_buf import if_fetch_pkg::*; (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_unload,
   input  logic         i_clear,
   input  fetch_entry_t i_entry,
   output fetch_entry_t o_entry,
   output logic         o_valid
);
   fetch_entry_t r_entry;
   logic         r_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_entry <= '0;
         r_valid <= 1'b0;
      end else if (i_clear) begin
         r_entry <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_entry <= i_entry;
         r_valid <= 1'b1;
      end else if (i_unload) begin
         r_entry <= '0;
         r_valid <= 1'b0;
      end
   end

   assign o_entry = r_entry;
   assign o_valid = r_valid;
endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, imem request FSM, redirect handling and
// the IF/ID output register, with a one-entry skid for ID-side stalls.
module if_fetch import if_fetch_pkg::*; #(
   parameter logic [INST_ADDR_BUS-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [INST_ADDR_BUS-1:0] PC_STEP  = 32'd4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     flush,
   input  logic [INST_ADDR_BUS-1:0] newPC,
   input  logic                     branchFlag,
   input  logic [INST_ADDR_BUS-1:0] branchTarget,
   if_fetch_if.master               imem,
   output logic [INST_ADDR_BUS-1:0] ifPC,
   output logic [INST_BUS-1:0]      ifInst,
   output logic                     ifValid
);
   logic [FETCH_STATE_BUS-1:0] r_state, w_state_nxt;
   logic [INST_ADDR_BUS-1:0]   r_pc, w_pc_nxt;
   logic [INST_ADDR_BUS-1:0]   r_addr, w_addr_nxt;
   logic [INST_ADDR_BUS-1:0]   r_if_pc;
   logic [INST_BUS-1:0]        r_if_inst;
   logic                       r_if_valid;

   logic                     w_slot_free, w_redir, w_ack, w_take, w_park, w_unpark;
   logic [INST_ADDR_BUS-1:0] w_target, w_step;
   fetch_entry_t             w_skid_entry;
   logic                     w_skid_valid;

   assign w_slot_free = !r_if_valid || !stall;
   assign w_redir     = flush || (branchFlag && !stall);
   assign w_target    = word_align(flush ? newPC : branchTarget);
   assign w_ack       = imem.imemAck;
   assign w_step      = r_addr + PC_STEP;

   // Acks outside REQ/DISCARD are ignored by construction of these terms.
   assign w_take   = (r_state == REQ) && w_ack && w_slot_free && !w_redir;
   assign w_park   = (r_state == REQ) && w_ack && !w_slot_free && !w_redir;
   assign w_unpark = (r_state == HOLD) && !stall && !w_redir;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_addr_nxt  = r_addr;
      if (w_redir) begin
         w_pc_nxt = w_target;
         if ((r_state == REQ || r_state == DISCARD) && !w_ack) begin
            w_state_nxt = DISCARD;
         end else begin
            w_state_nxt = REQ;
            w_addr_nxt  = w_target;
         end
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = REQ;
               w_addr_nxt  = r_pc;
            end
            REQ: begin
               if (w_ack) begin
                  w_pc_nxt = w_step;
                  if (w_slot_free) w_addr_nxt  = w_step;
                  else             w_state_nxt = HOLD;
               end
            end
            HOLD: begin
               if (!stall) begin
                  w_state_nxt = REQ;
                  w_addr_nxt  = r_pc;
               end
            end
            default: begin
               if (w_ack) begin
                  w_state_nxt = REQ;
                  w_addr_nxt  = r_pc;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC;
         r_addr  <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_addr  <= w_addr_nxt;
      end
   end

   // IF/ID register: redirect squashes even under stall; stall alone holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_if_pc    <= ZERO_WORD;
         r_if_inst  <= ZERO_WORD;
         r_if_valid <= 1'b0;
      end else if (w_redir) begin
         r_if_pc    <= ZERO_WORD;
         r_if_inst  <= ZERO_WORD;
         r_if_valid <= 1'b0;
      end else if (w_take) begin
         r_if_pc    <= r_addr;
         r_if_inst  <= imem.imemData;
         r_if_valid <= 1'b1;
      end else if (w_unpark) begin
         r_if_pc    <= w_skid_entry.pc;
         r_if_inst  <= w_skid_entry.inst;
         r_if_valid <= w_skid_valid;
      end else if (!stall) begin
         r_if_pc    <= ZERO_WORD;
         r_if_inst  <= ZERO_WORD;
         r_if_valid <= 1'b0;
      end
   end

   if_skid_buf u_skid (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_park),
      .i_unload (w_unpark),
      .i_clear  (w_redir),
      .i_entry  ('{pc: r_addr, inst: imem.imemData}),
      .o_entry  (w_skid_entry),
      .o_valid  (w_skid_valid)
   );

   assign imem.imemReq  = (r_state == REQ) || (r_state == DISCARD);
   assign imem.imemAddr = r_addr;
   assign ifPC          = r_if_pc;
   assign ifInst        = r_if_inst;
   assign ifValid       = r_if_valid;
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a latency-programmable imem model whose
// instruction word is the fetch address XOR a fixed key.
module tb_if_fetch;
   localparam logic [31:0] KEY = 32'hDEAD_0000;

   logic        clk, rst, stall, flush, branchFlag;
   logic [31:0] newPC, branchTarget, ifPC, ifInst;
   logic        ifValid;
   logic [3:0]  mem_wait, mem_lat;
   int          n_pass, n_total;

   if_fetch_if imem ();

   if_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .newPC(newPC),
      .branchFlag(branchFlag), .branchTarget(branchTarget), .imem(imem),
      .ifPC(ifPC), .ifInst(ifInst), .ifValid(ifValid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // imem model: ack after mem_lat cycles of continuous request.
   assign imem.imemAck  = imem.imemReq && (mem_wait == mem_lat);
   assign imem.imemData = imem.imemAddr ^ KEY;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                mem_wait <= '0;
      else if (!imem.imemReq || imem.imemAck)  mem_wait <= '0;
      else                                     mem_wait <= mem_wait + 4'd1;
   end

   always @(posedge clk)
      if (rst) assert (!(imem.imemAck && !imem.imemReq))
         else $error("FAIL ack_protocol: imemAck while imemReq low");

   typedef struct packed {
      logic        stall;
      logic        br;
      logic [31:0] tgt;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                             input logic v, input logic [31:0] pc);
      chk({tag, ".imemReq"},  {31'd0, imem.imemReq}, {31'd0, req});
      chk({tag, ".imemAddr"}, imem.imemAddr, addr);
      chk({tag, ".ifValid"},  {31'd0, ifValid}, {31'd0, v});
      chk({tag, ".ifPC"},     ifPC, v ? pc : 32'h0);
      chk({tag, ".ifInst"},   ifInst, v ? (pc ^ KEY) : 32'h0);
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst = 1'b0; stall = 1'b0; flush = 1'b0; branchFlag = 1'b0;
      newPC = '0; branchTarget = '0; mem_lat = 4'd0;

      //           stall br  tgt         req  addr          v     pc
      tbl[0] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0000_0000, 1'b0, 32'h0};
      tbl[1] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0000_0004, 1'b1, 32'h0};
      tbl[2] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0000_0008, 1'b1, 32'h4};
      tbl[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0000_000C, 1'b1, 32'h8};
      tbl[4] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0000_0010, 1'b1, 32'hC};
      tbl[5] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0000_0010, 1'b1, 32'hC};
      tbl[6] = '{1'b1, 1'b1, 32'h40, 1'b0, 32'h0000_0010, 1'b1, 32'hC};
      tbl[7] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0000_0010, 1'b1, 32'hC};
      tbl[8] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0000_0014, 1'b1, 32'h10};
      tbl[9] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0000_0018, 1'b1, 32'h14};

      repeat (2) @(negedge clk);
      expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
      rst = 1'b1;

      // Zero-wait streaming, then a 3-cycle stall with the parked word for 0x10.
      for (int i = 0; i < 10; i++) begin
         stall = tbl[i].stall;
         branchFlag = tbl[i].br;
         branchTarget = tbl[i].tgt;
         cyc();
         expect_out($sformatf("vec%0d", i), tbl[i].exp_req, tbl[i].exp_addr,
                    tbl[i].exp_valid, tbl[i].exp_pc);
      end
      stall = 1'b0; branchFlag = 1'b0;

      // Two-cycle latency: one word every three cycles with NOP bubbles.
      mem_lat = 4'd2;
      for (int k = 0; k < 2; k++) begin
         cyc(); expect_out($sformatf("lat2_%0d_b0", k), 1'b1, 32'h18 + 32'(4 * k), 1'b0, 32'h0);
         cyc(); expect_out($sformatf("lat2_%0d_b1", k), 1'b1, 32'h18 + 32'(4 * k), 1'b0, 32'h0);
         cyc(); expect_out($sformatf("lat2_%0d_v", k),  1'b1, 32'h1C + 32'(4 * k), 1'b1, 32'h18 + 32'(4 * k));
      end

      // Branch to 0x103 while 0x20 is in flight: 0x20 is discarded.
      branchFlag = 1'b1; branchTarget = 32'h0000_0103;
      cyc(); expect_out("br_d0", 1'b1, 32'h20, 1'b0, 32'h0);
      branchFlag = 1'b0; branchTarget = 32'h0;
      cyc(); expect_out("br_d1", 1'b1, 32'h20, 1'b0, 32'h0);
      cyc(); expect_out("br_req", 1'b1, 32'h100, 1'b0, 32'h0);
      cyc(); expect_out("br_w0", 1'b1, 32'h100, 1'b0, 32'h0);
      cyc(); expect_out("br_w1", 1'b1, 32'h100, 1'b0, 32'h0);
      cyc(); expect_out("br_v", 1'b1, 32'h104, 1'b1, 32'h100);

      // Flush and branch together under stall: flush target wins, ifValid drops.
      stall = 1'b1; flush = 1'b1; newPC = 32'h180;
      branchFlag = 1'b1; branchTarget = 32'h200;
      cyc(); expect_out("fl_d0", 1'b1, 32'h104, 1'b0, 32'h0);
      stall = 1'b0; flush = 1'b0; branchFlag = 1'b0; newPC = '0; branchTarget = '0;
      cyc(); expect_out("fl_d1", 1'b1, 32'h104, 1'b0, 32'h0);
      cyc(); expect_out("fl_req", 1'b1, 32'h180, 1'b0, 32'h0);

      // Flush to 0xFFFF_FFF8 over a same-cycle ack, then wrap through zero.
      mem_lat = 4'd0; flush = 1'b1; newPC = 32'hFFFF_FFF8;
      cyc(); expect_out("wr_req", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
      flush = 1'b0; newPC = '0;
      cyc(); expect_out("wr_0", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8);
      cyc(); expect_out("wr_1", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC);
      cyc(); expect_out("wr_2", 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);

      // Asynchronous reset in the middle of a request.
      rst = 1'b0;
      #1 expect_out("arst", 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      cyc(); expect_out("rs_0", 1'b1, 32'h0, 1'b0, 32'h0);
      cyc(); expect_out("rs_1", 1'b1, 32'h4, 1'b1, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Owns the PC and fetches one instruction per request over a variable-latency instruction-memory handshake.
- Presents fetched instructions as ifPC/ifInst/ifValid to the IF/ID pipeline register.
- Absorbs ID-side stalls with a one-entry skid buffer.
- Redirects on branch or flush, draining any stale in-flight request.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- stall  input  1  IF/ID cannot accept; hold outputs
- flush  input  1  exception/pipeline flush
- newPC  input  32  flush target
- branchFlag  input  1  taken branch/jump from ID
- branchTarget  input  32  branch target
- imemReq  output  1  fetch request valid
- imemAddr  output  32  fetch address
- imemAck  input  1  response valid (same cycle as request or later)
- imemData  input  32  instruction word, valid with imemAck
- ifPC  output  32  PC of presented instruction
- ifInst  output  32  presented instruction
- ifValid  output  1  ifPC/ifInst hold a real instruction

Behaviour:
- Reset (rst=0, async) values:
  - pc=RESET_PC, state=IDLE.
  - imemReq=0, imemAddr=RESET_PC.
  - ifPC=0, ifInst=0, ifValid=0.
  - Skid buffer empty.
- States:
  - IDLE: no request outstanding. Next cycle goes to REQ with imemAddr=pc.
  - REQ: imemReq=1. imemAddr is a registered copy of the fetch address, stable until imemAck.
  - HOLD: response parked in skid; imemReq=0.
  - DISCARD: imemReq=1 at the stale address until imemAck; data is dropped.
- At most one request outstanding.
- Slot free = !ifValid || !stall.
- REQ, imemAck=1, slot free:
  - ifPC<=imemAddr, ifInst<=imemData, ifValid<=1.
  - pc<=imemAddr+PC_STEP; stay REQ with imemAddr<=pc+PC_STEP.
  - With a same-cycle ack this gives 1 instruction/cycle.
- REQ, imemAck=1, slot not free: capture {addr,data} into skid, go HOLD.
- HOLD, stall=0: skid -> outputs, ifValid<=1, skid cleared, go REQ at next pc.
- No new data and stall=0: ifValid<=0, ifInst<=0 (bubble = NOP), ifPC<=0.
- stall=1 without redirect: outputs hold unchanged.
- Redirect priority: flush > branchFlag. flush always acts; branchFlag acts only when stall=0.
- Redirect, target = newPC or branchTarget with bits[1:0] forced to 0:
  - pc<=target; ifValid<=0, ifInst<=0; skid cleared.
  - REQ with no ack this cycle -> DISCARD. On ack, drop data and go REQ at target.
  - REQ with ack this cycle -> data dropped, REQ at target next cycle.
  - HOLD or IDLE -> REQ at target next cycle.
  - DISCARD -> stay DISCARD; the latest target replaces pc.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- imemAck in IDLE or HOLD is a protocol violation: ignored, with an assertion in the bench.
- Reset mid-request: all state returns to reset values immediately. The memory is reset by the same rst, so no drain is required.

Decomposition:
- Shared define file:
  - INST_ADDR_BUS, INST_BUS, ZERO_WORD (existing).
  - New FETCH_STATE_BUS plus state encodings IDLE/REQ/HOLD/DISCARD.
- One sub-module: if_skid_buf. One-entry {pc,inst,valid} register with load/unload/clear, async active-low reset.
- FSM, PC register and redirect logic stay in if_fetch.

Test Plan:
- Reset release with ack tied to imemReq (zero-wait), stall=0 -> imemAddr 0,4,8,12 on consecutive cycles. ifPC follows one cycle later: 0,4,8 with ifValid=1 from cycle 2.
- 2-cycle ack latency -> one instruction every 3 cycles. ifValid pulses; bubble cycles show ifInst=0, ifValid=0.
- stall=1 held 3 cycles while ack arrives for PC 0x10:
  - Outputs hold PC 0x0C, data parked, imemReq=0.
  - On stall release, ifPC=0x10 next cycle, then fetch 0x14.
- branchFlag with branchTarget=0x0000_0103 while a request for 0x20 is outstanding (ack 2 cycles later):
  - Data for 0x20 is never presented.
  - Next imemAddr=0x100; ifValid=0 until 0x100 returns.
- flush (newPC=0x180) and branchFlag in the same cycle, stall=1 -> flush wins, next fetch address 0x180, ifValid cleared despite stall.
- Start at pc=0xFFFF_FFF8 -> fetch 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Assert rst=0 mid-request -> all outputs 0 and imemReq=0 immediately, restart at RESET_PC.
